// File: rtl/tlc549_pkg.sv
// Shared types and constants for the TLC549 serial front-end.
// Holds the FSM state encoding, ADC word width and default 50 MHz timing.
// Pure declarations; no logic, no latency, no flow control.
package tlc549_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CONV  = 2'd3
    } state_e;

    localparam int ADC_BITS = 8;

    // Defaults for a 50 MHz csi_clk: 1 MHz I/O CLK, 2 us CS setup, 20 us conversion.
    localparam int DEF_IO_CLK_DIV   = 25;
    localparam int DEF_CS_SETUP_CYC = 100;
    localparam int DEF_CONV_CYC     = 1000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/zircon_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clock cycles from input to output.
// No backpressure; samples every cycle.
module zircon_sync2 (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops resolve metastability before the bit is used.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/zircon_tlc549_serial_ctrl.sv
// TLC549 serial front-end: drives CS_n / I/O CLK, shifts result MSB-first, presents it in parallel.
// Latency: one frame = CS_SETUP_CYC + 16*IO_CLK_DIV + CONV_CYC cycles; result appears on CONV entry.
// No backpressure: data_valid is a one-cycle strobe and data_out holds until the next one.
module zircon_tlc549_serial_ctrl
    import tlc549_pkg::*;
#(
    parameter int IO_CLK_DIV   = DEF_IO_CLK_DIV,
    parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
    parameter int CONV_CYC     = DEF_CONV_CYC
) (
    input  logic                csi_clk,
    input  logic                rsi_reset_n,
    input  logic                conv_en,
    input  logic                ad_data,
    output logic                ad_cs_n,
    output logic                ad_io_clk,
    output logic [ADC_BITS-1:0] data_out,
    output logic                data_valid
);

    localparam int CW = $clog2(max3(CS_SETUP_CYC, IO_CLK_DIV, CONV_CYC)) + 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(IO_CLK_DIV - 1);
    localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_CYC - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic                high_q, high_d;     // in SHIFT: 1 = high half of the SCLK period
    logic [ADC_BITS-1:0] shift_q, shift_d;
    logic                primed_q, primed_d; // ADC now holds a result from a frame we clocked
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic [ADC_BITS-1:0] data_q, data_d;
    logic                vld_q, vld_d;
    logic                ad_data_s;

    zircon_sync2 u_sync_data (
        .clk_i    (csi_clk),
        .arst_n_i (rsi_reset_n),
        .d_i      (ad_data),
        .q_o      (ad_data_s)
    );

    // State, counters and registered pin drivers.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            high_q   <= 1'b0;
            shift_q  <= '0;
            primed_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            data_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            high_q   <= high_d;
            shift_q  <= shift_d;
            primed_q <= primed_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
        end
    end

    // Next-state: frame sequencing, SCLK half-period timing, shift and result handoff.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        high_d   = high_q;
        shift_d  = shift_q;
        primed_d = primed_q;
        data_d   = data_q;
        vld_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (conv_en) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    high_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (high_q) begin
                        // Last cycle of the high half: the bit has been stable since the prior fall.
                        shift_d = {shift_q[ADC_BITS-2:0], ad_data_s};
                        high_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        high_d = 1'b1;
                        if (bit_q == 3'd7) begin
                            high_d  = 1'b0;
                            state_d = ST_CONV;
                            // The first frame after reset/idle returns a stale result; drop it.
                            if (primed_q) begin
                                data_d = shift_q;
                                vld_d  = 1'b1;
                            end else begin
                                primed_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    cnt_d = '0;
                    if (conv_en) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d  = ST_IDLE;
                        primed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pins are decoded from the next state so the registered outputs line up with the state.
        cs_n_d = (state_d == ST_IDLE) || (state_d == ST_CONV);
        sclk_d = (state_d == ST_SHIFT) && high_d;
    end

    assign ad_cs_n    = cs_n_q;
    assign ad_io_clk  = sclk_q;
    assign data_out   = data_q;
    assign data_valid = vld_q;

endmodule

// File: tb/tb_zircon_tlc549_serial_ctrl.sv
// Bench for the TLC549 serial front-end with a behavioural ADC and a result scoreboard.
// Frames are checked cycle-by-cycle against the expected CS_n / SCLK / valid waveform.
// ADC results expected to be handed off are queued at CS_n fall and popped on data_valid.
module tb_zircon_tlc549_serial_ctrl;

    localparam int DIV       = 2;
    localparam int SETUP     = 4;
    localparam int CONV      = 8;
    localparam int SHIFT_END = SETUP + 16 * DIV;
    localparam int FRAME     = SHIFT_END + CONV;

    typedef struct {
        logic [7:0] val;
        logic       exp_vld;
    } frame_t;

    logic       csi_clk = 1'b0;
    logic       rsi_reset_n = 1'b0;
    logic       conv_en = 1'b0;
    logic       ad_data;
    logic       ad_cs_n;
    logic       ad_io_clk;
    logic [7:0] data_out;
    logic       data_valid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    frame_t     stim_q[$];
    logic [7:0] sb_q[$];
    int         vld_cyc_q[$];
    frame_t     tbl[5];

    zircon_tlc549_serial_ctrl #(
        .IO_CLK_DIV   (DIV),
        .CS_SETUP_CYC (SETUP),
        .CONV_CYC     (CONV)
    ) dut (
        .csi_clk     (csi_clk),
        .rsi_reset_n (rsi_reset_n),
        .conv_en     (conv_en),
        .ad_data     (ad_data),
        .ad_cs_n     (ad_cs_n),
        .ad_io_clk   (ad_io_clk),
        .data_out    (data_out),
        .data_valid  (data_valid)
    );

    always #5 csi_clk = ~csi_clk;

    always @(posedge csi_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC: MSB at CS_n fall, next bit one cycle after each SCLK fall.
    task automatic adc_model();
        logic       prev_cs, prev_sclk, pend;
        logic [7:0] val;
        int         idx;
        frame_t     f;
        prev_cs = 1'b1; prev_sclk = 1'b0; pend = 1'b0; val = '0; idx = 0;
        ad_data = 1'b0;
        forever begin
            @(negedge csi_clk);
            if (!rsi_reset_n) begin
                prev_cs = 1'b1; prev_sclk = 1'b0; pend = 1'b0; idx = 0;
            end else begin
                if (pend) begin
                    pend = 1'b0;
                    if (idx < 8) ad_data = val[7-idx];
                end
                if (prev_cs && !ad_cs_n) begin
                    if (stim_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL stim_underflow: frame started with no stimulus queued (cycle %0d)", cyc);
                        val = '0;
                    end else begin
                        f   = stim_q.pop_front();
                        val = f.val;
                        if (f.exp_vld) sb_q.push_back(f.val);
                    end
                    idx = 0;
                    ad_data = val[7];
                end
                if (prev_sclk && !ad_io_clk) begin
                    idx++;
                    pend = 1'b1;
                end
                prev_cs = ad_cs_n;
                prev_sclk = ad_io_clk;
            end
        end
    endtask

    // Scoreboard: every data_valid must match the oldest expected result.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge csi_clk);
            if (rsi_reset_n && data_valid) begin
                vld_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: data_out=%h with no result expected (cycle %0d)", data_out, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", 32'(data_out), 32'(e));
                end
            end
        end
    endtask

    task automatic wait_cs_fall(output bit found);
        logic prev;
        prev = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge csi_clk);
            if (prev && !ad_cs_n) found = 1'b1;
            prev = ad_cs_n;
        end
        chk("cs_fall_timeout", 32'(found), 32'd1);
    endtask

    // Check one full frame from CS_n fall; optional conv_en drop or CONV glitch.
    task automatic check_frame(input logic exp_vld, input logic [7:0] exp_dat,
                               input int drop_at, input bit glitch);
        bit         found;
        int         bad, first_bad;
        logic [2:0] ew, aw;
        wait_cs_fall(found);
        if (found) begin
            bad = 0; first_bad = -1;
            for (int i = 0; i < FRAME; i++) begin
                ew[2] = (i >= SHIFT_END);
                ew[1] = (i >= SETUP) && (i < SHIFT_END) && (((i - SETUP) % (2 * DIV)) < DIV);
                ew[0] = exp_vld && (i == SHIFT_END);
                aw = {ad_cs_n, ad_io_clk, data_valid};
                if (aw !== ew) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
                if (exp_vld && i == SHIFT_END) chk("frame_data", 32'(data_out), 32'(exp_dat));
                if (i == drop_at) conv_en = 1'b0;
                if (glitch && i == SHIFT_END + 2) conv_en = 1'b0;
                if (glitch && i == SHIFT_END + 4) conv_en = 1'b1;
                if (i < FRAME - 1) @(negedge csi_clk);
            end
            if (bad != 0) $display("  frame waveform first differs at frame cycle %0d", first_bad);
            chk("frame_wave", 32'(bad), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int bad;

        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h3C, 1'b1};
        tbl[2] = '{8'h5A, 1'b1};
        tbl[3] = '{8'hC3, 1'b1};
        tbl[4] = '{8'h81, 1'b1};

        fork
            adc_model();
            monitor();
        join_none

        // Reset held, then released with conv_en low.
        repeat (5) @(negedge csi_clk);
        chk("reset_outputs", 32'({ad_cs_n, ad_io_clk, data_out, data_valid}), 32'({1'b1, 1'b0, 8'h00, 1'b0}));
        rsi_reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge csi_clk);
            chk("idle_outputs", 32'({ad_cs_n, ad_io_clk, data_out, data_valid}), 32'({1'b1, 1'b0, 8'h00, 1'b0}));
        end

        // Back-to-back frames from the table; first one is discarded.
        foreach (tbl[k]) stim_q.push_back(tbl[k]);
        conv_en = 1'b1;
        for (int k = 0; k < 5; k++) check_frame(tbl[k].exp_vld, tbl[k].val, -1, (k == 2));
        chk("vld_count", 32'(vld_cyc_q.size()), 32'd4);
        for (int k = 1; k < vld_cyc_q.size(); k++)
            chk("vld_spacing", 32'(vld_cyc_q[k] - vld_cyc_q[k-1]), 32'(FRAME));
        vld_cyc_q.delete();

        // conv_en dropped mid-SHIFT: frame completes, then IDLE.
        stim_q.push_back('{8'h96, 1'b1});
        check_frame(1'b1, 8'h96, 20, 1'b0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge csi_clk);
            if ({ad_cs_n, ad_io_clk, data_valid} !== 3'b100) bad++;
        end
        chk("idle_after_drop", 32'(bad), 32'd0);
        chk("data_hold_idle", 32'(data_out), 32'h96);

        // Re-enable: next frame discarded, the one after captured, then one aborted by reset.
        stim_q.push_back('{8'h11, 1'b0});
        stim_q.push_back('{8'hE7, 1'b1});
        stim_q.push_back('{8'h4E, 1'b0});
        conv_en = 1'b1;
        check_frame(1'b0, 8'h11, -1, 1'b0);
        check_frame(1'b1, 8'hE7, -1, 1'b0);

        // Asynchronous reset during SHIFT bit 4.
        wait_cs_fall(found);
        repeat (SETUP + 16 + 1) @(negedge csi_clk);
        chk("pre_reset_sclk", 32'(ad_io_clk), 32'd1);
        chk("pre_reset_data", 32'(data_out), 32'hE7);
        #2 rsi_reset_n = 1'b0;
        #1 chk("async_reset_outputs", 32'({ad_cs_n, ad_io_clk, data_out, data_valid}),
               32'({1'b1, 1'b0, 8'h00, 1'b0}));
        repeat (3) @(negedge csi_clk);
        stim_q.push_back('{8'h00, 1'b0});
        stim_q.push_back('{8'hFF, 1'b1});
        stim_q.push_back('{8'h00, 1'b1});
        rsi_reset_n = 1'b1;
        check_frame(1'b0, 8'h00, -1, 1'b0);
        check_frame(1'b1, 8'hFF, -1, 1'b0);
        check_frame(1'b1, 8'h00, FRAME - 1, 1'b0);

        repeat (20) @(negedge csi_clk);
        chk("final_idle_cs", 32'(ad_cs_n), 32'd1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("stim_empty", 32'(stim_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
